// File: rtl/misr_bist_sequencer.sv
// MISR self-test sequencer: drives the MISR register port, streams LFSR stimulus,
// reads back the signature and compares it against a golden value.
module misr_bist_sequencer #(
  parameter int unsigned          NBIT_DATA  = 64,
  parameter int unsigned          NBIT_ADDR  = 64,
  parameter int unsigned          NBIT_CNT   = 32,
  parameter logic [NBIT_ADDR-1:0] START_ADDR = NBIT_ADDR'(2**25),
  parameter logic [NBIT_DATA-1:0] LFSR_POLY  = NBIT_DATA'(64'hD800_0000_0000_0000)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [NBIT_DATA-1:0] coeff_i,
  input  logic [NBIT_DATA-1:0] seed_i,
  input  logic [NBIT_DATA-1:0] golden_i,
  input  logic [NBIT_CNT-1:0]  n_words_i,
  output logic                 re_o,
  output logic                 we_o,
  output logic [NBIT_ADDR-1:0] addr_o,
  output logic [NBIT_DATA-1:0] wdata_o,
  input  logic [NBIT_DATA-1:0] rdata_i,
  output logic [NBIT_DATA-1:0] data_misr_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [NBIT_DATA-1:0] signature_o
);

  localparam logic [NBIT_ADDR-1:0] ADDR_CTRL = START_ADDR;
  localparam logic [NBIT_ADDR-1:0] ADDR_COEF = START_ADDR + NBIT_ADDR'(8);
  localparam logic [NBIT_ADDR-1:0] ADDR_SIG  = START_ADDR + NBIT_ADDR'(16);
  localparam logic [NBIT_DATA-1:0] CTRL_RUN  = NBIT_DATA'(2'b11);
  localparam logic [NBIT_DATA-1:0] CTRL_HALT = NBIT_DATA'(2'b10);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_COEF, S_EN, S_STREAM, S_STOP, S_SETTLE, S_READ, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NBIT_DATA-1:0] coeff_q, coeff_d;
  logic [NBIT_DATA-1:0] golden_q, golden_d;
  logic [NBIT_DATA-1:0] lfsr_q, lfsr_d;
  logic [NBIT_CNT-1:0]  n_q, n_d;
  logic [NBIT_CNT-1:0]  cnt_q, cnt_d;

  logic                 re_d, we_d, busy_d, done_d;
  logic [NBIT_ADDR-1:0] addr_d;
  logic [NBIT_DATA-1:0] wdata_d, data_misr_d;

  function automatic logic [NBIT_DATA-1:0] lfsr_step(input logic [NBIT_DATA-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

  // Next-state, latches and stimulus generator
  always_comb begin
    state_d  = state_q;
    coeff_d  = coeff_q;
    golden_d = golden_q;
    lfsr_d   = lfsr_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_CLR;
          coeff_d  = coeff_i;
          golden_d = golden_i;
          lfsr_d   = seed_i;
          n_d      = n_words_i;
        end
      end
      S_CLR:  state_d = S_COEF;
      S_COEF: state_d = (n_q != '0) ? S_EN : S_STOP;
      S_EN: begin
        cnt_d   = n_q - NBIT_CNT'(1);
        lfsr_d  = lfsr_step(lfsr_q);
        state_d = (n_q == NBIT_CNT'(1)) ? S_STOP : S_STREAM;
      end
      S_STREAM: begin
        cnt_d  = cnt_q - NBIT_CNT'(1);
        lfsr_d = lfsr_step(lfsr_q);
        if (cnt_q == NBIT_CNT'(1)) state_d = S_STOP;
      end
      S_STOP:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_READ;
      S_READ:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output comes straight off a flop
  always_comb begin
    re_d        = 1'b0;
    we_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    data_misr_d = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    case (state_d)
      S_CLR: begin
        we_d   = 1'b1;
        addr_d = ADDR_CTRL;
      end
      S_COEF: begin
        we_d    = 1'b1;
        addr_d  = ADDR_COEF;
        wdata_d = coeff_d;
      end
      S_EN: begin
        we_d        = 1'b1;
        addr_d      = ADDR_CTRL;
        wdata_d     = CTRL_RUN;
        data_misr_d = lfsr_d;
      end
      S_STREAM: data_misr_d = lfsr_d;
      S_STOP: begin
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = CTRL_HALT;
      end
      S_READ: begin
        re_d   = 1'b1;
        addr_d = ADDR_SIG;
      end
      default: ;
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      coeff_q     <= '0;
      golden_q    <= '0;
      lfsr_q      <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      re_o        <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= '0;
      data_misr_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      signature_o <= '0;
    end else begin
      state_q     <= state_d;
      coeff_q     <= coeff_d;
      golden_q    <= golden_d;
      lfsr_q      <= lfsr_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      re_o        <= re_d;
      we_o        <= we_d;
      addr_o      <= addr_d;
      wdata_o     <= wdata_d;
      data_misr_o <= data_misr_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      // Verdict is ready alongside the done pulse
      if (state_q == S_READ) begin
        signature_o <= rdata_i;
        pass_o      <= (rdata_i == golden_q);
      end else if (state_q == S_IDLE && start_i) begin
        pass_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_misr_bist_sequencer.sv
// Scoreboard bench for misr_bist_sequencer with a behavioural MISR peripheral on the bus.
module tb_misr_bist_sequencer;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i;
  logic [63:0] coeff_i, seed_i, golden_i;
  logic [31:0] n_words_i;
  logic        re_o, we_o, busy_o, done_o, pass_o;
  logic [63:0] addr_o, wdata_o, rdata_i, data_misr_o, signature_o;

  misr_bist_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .coeff_i(coeff_i), .seed_i(seed_i),
    .golden_i(golden_i), .n_words_i(n_words_i), .re_o(re_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rdata_i(rdata_i), .data_misr_o(data_misr_o), .busy_o(busy_o),
    .done_o(done_o), .pass_o(pass_o), .signature_o(signature_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { longint unsigned cyc; bit rd; logic [63:0] addr; logic [63:0] data; } bus_exp_t;
  typedef struct { longint unsigned cyc; logic [63:0] word; } word_exp_t;
  typedef struct { longint unsigned cyc; logic [63:0] sig; bit pass; } done_exp_t;

  bus_exp_t  bus_q[$];
  word_exp_t word_q[$];
  done_exp_t done_q[$];
  int checks = 0;
  int errors = 0;
  longint unsigned cyc = 0;
  bit stub_zero = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [63:0] galois(input logic [63:0] s, input logic [63:0] p);
    return (s >> 1) ^ (s[0] ? p : 64'h0);
  endfunction

  // Signature the peripheral should hold after absorbing the n stimulus words
  function automatic logic [63:0] model_sig(input logic [63:0] coeff, input logic [63:0] seed,
                                            input int unsigned n);
    logic [63:0] s = seed;
    logic [63:0] m = 64'h0;
    for (int unsigned k = 0; k < n; k++) begin
      m = galois(m, coeff) ^ s;
      s = galois(s, POLY);
    end
    return m;
  endfunction

  // Behavioural MISR peripheral: ctrl bit1 = out of reset, bit0 = enable
  logic [63:0] p_ctrl, p_coeff, p_misr, p_sig, eff_ctrl;
  assign eff_ctrl = (we_o && addr_o == BASE) ? wdata_o : p_ctrl;
  assign rdata_i  = (re_o && addr_o == BASE + 64'd16) ? (stub_zero ? 64'h0 : p_sig) : 64'h0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_ctrl <= 64'h0; p_coeff <= 64'h0; p_misr <= 64'h0; p_sig <= 64'h0;
    end else begin
      if (we_o && addr_o == BASE) p_ctrl <= wdata_o;
      if (we_o && addr_o == BASE + 64'd8) p_coeff <= wdata_o;
      if (!eff_ctrl[1]) p_misr <= 64'h0;
      else if (eff_ctrl[0]) p_misr <= galois(p_misr, p_coeff) ^ data_misr_o;
      p_sig <= p_misr;
    end
  end

  // Expected bus trace, stimulus words and verdict for a run whose CLR cycle is t0
  task automatic queue_run(input longint unsigned t0, input logic [63:0] coeff,
                           input logic [63:0] seed, input logic [63:0] gold,
                           input int unsigned n, input bit stub0);
    logic [63:0] s = seed;
    logic [63:0] sig;
    longint unsigned stop_rel = (n == 0) ? 3 : longint'(n) + 3;
    bus_q.push_back('{t0, 1'b0, BASE, 64'h0});
    bus_q.push_back('{t0 + 1, 1'b0, BASE + 64'd8, coeff});
    if (n > 0) begin
      bus_q.push_back('{t0 + 2, 1'b0, BASE, 64'd3});
      for (int unsigned k = 0; k < n; k++) begin
        word_q.push_back('{t0 + 2 + longint'(k), s});
        s = galois(s, POLY);
      end
    end
    bus_q.push_back('{t0 + stop_rel - 1, 1'b0, BASE, 64'd2});
    bus_q.push_back('{t0 + stop_rel + 1, 1'b1, BASE + 64'd16, 64'h0});
    sig = stub0 ? 64'h0 : model_sig(coeff, seed, n);
    done_q.push_back('{t0 + stop_rel + 2, sig, sig == gold});
  endtask

  // Monitor: compare DUT presentations against the scoreboard queues
  always @(negedge clk_i) begin
    if (rst_ni) begin
      logic [63:0] exp_word;
      while (bus_q.size() > 0 && bus_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL bus_missing cyc=%0d got none want rd=%0b addr=%h at cyc=%0d",
                 cyc, bus_q[0].rd, bus_q[0].addr, bus_q[0].cyc);
        void'(bus_q.pop_front());
      end
      if (re_o || we_o) begin
        checks++;
        if (re_o && we_o) begin
          errors++; $display("FAIL bus_both cyc=%0d got re=1 we=1 want one strobe", cyc);
        end else if (bus_q.size() == 0 || bus_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL bus_unexpected cyc=%0d got re=%0b we=%0b addr=%h want no access",
                   cyc, re_o, we_o, addr_o);
        end else begin
          if (re_o != bus_q[0].rd || addr_o != bus_q[0].addr ||
              (we_o && wdata_o != bus_q[0].data)) begin
            errors++;
            $display("FAIL bus_access cyc=%0d got re=%0b addr=%h data=%h want rd=%0b addr=%h data=%h",
                     cyc, re_o, addr_o, wdata_o, bus_q[0].rd, bus_q[0].addr, bus_q[0].data);
          end
          void'(bus_q.pop_front());
        end
      end else begin
        checks++;
        if (addr_o != 64'h0 || wdata_o != 64'h0) begin
          errors++;
          $display("FAIL bus_quiet cyc=%0d got addr=%h wdata=%h want 0 0", cyc, addr_o, wdata_o);
        end
      end
      while (word_q.size() > 0 && word_q[0].cyc < cyc) void'(word_q.pop_front());
      exp_word = 64'h0;
      if (word_q.size() > 0 && word_q[0].cyc == cyc) exp_word = word_q.pop_front().word;
      checks++;
      if (data_misr_o != exp_word) begin
        errors++;
        $display("FAIL data_misr cyc=%0d got %h want %h", cyc, data_misr_o, exp_word);
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing cyc=%0d got no done want done at cyc=%0d", cyc, done_q[0].cyc);
        void'(done_q.pop_front());
      end
      if (done_o) begin
        checks++;
        if (done_q.size() == 0 || done_q[0].cyc != cyc) begin
          errors++; $display("FAIL done_unexpected cyc=%0d got done=1 want 0", cyc);
        end else begin
          if (signature_o != done_q[0].sig || pass_o != done_q[0].pass || !busy_o) begin
            errors++;
            $display("FAIL done_result cyc=%0d got sig=%h pass=%0b busy=%0b want sig=%h pass=%0b busy=1",
                     cyc, signature_o, pass_o, busy_o, done_q[0].sig, done_q[0].pass);
          end
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({re_o, we_o, busy_o, done_o, pass_o} != 5'b0 || addr_o != 64'h0 || wdata_o != 64'h0 ||
        data_misr_o != 64'h0 || signature_o != 64'h0) begin
      errors++;
      $display("FAIL %s got re=%0b we=%0b busy=%0b done=%0b pass=%0b addr=%h wdata=%h data=%h sig=%h want all 0",
               name, re_o, we_o, busy_o, done_o, pass_o, addr_o, wdata_o, data_misr_o, signature_o);
    end
  endtask

  task automatic start_run(input logic [63:0] coeff, input logic [63:0] seed,
                           input logic [63:0] gold, input int unsigned n, input bit stub0);
    coeff_i = coeff; seed_i = seed; golden_i = gold; n_words_i = n; start_i = 1'b1;
    queue_run(cyc + 1, coeff, seed, gold, n, stub0);
    tick();
    start_i = 1'b0;
    coeff_i = {$urandom, $urandom}; seed_i = {$urandom, $urandom};
    golden_i = {$urandom, $urandom}; n_words_i = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus_q.size() != 0 || done_q.size() != 0 || word_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL run_timeout got %0d pending events after %0d cycles want 0",
               bus_q.size() + done_q.size() + word_q.size(), budget);
      bus_q.delete(); word_q.delete(); done_q.delete();
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish by %0t want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c, s, sig;
    longint unsigned t0;
    int unsigned n;
    rst_ni = 1'b1; start_i = 1'b0; coeff_i = 64'h0; seed_i = 64'h0;
    golden_i = 64'h0; n_words_i = 32'h0;
    #1 rst_ni = 1'b0;
    #2 check_zero("reset_async");
    repeat (3) tick();
    check_zero("reset_held");
    rst_ni = 1'b1;
    repeat (20) tick();
    check_zero("idle_after_reset");

    // N=0 with a stub that reads back zero
    stub_zero = 1'b1;
    start_run(64'h1B, {$urandom, $urandom}, 64'h0, 0, 1'b1);
    wait_idle(50);
    stub_zero = 1'b0;

    // N=3 from seed 1, matching golden then golden off by one bit
    c = {$urandom, $urandom};
    sig = model_sig(c, 64'h1, 3);
    start_run(c, 64'h1, sig, 3, 1'b0);
    wait_idle(50);
    start_run(c, 64'h1, sig ^ 64'h1, 3, 1'b0);
    wait_idle(50);

    // Single word and all-zero seed
    c = {$urandom, $urandom};
    start_run(c, {$urandom, $urandom}, model_sig(c, 64'h0, 0) ^ 64'h5, 1, 1'b0);
    wait_idle(50);
    start_run(c, 64'h0, 64'h0, 5, 1'b0);
    wait_idle(50);

    // Randomized runs with matching or corrupted golden
    for (int r = 0; r < 10; r++) begin
      c = {$urandom, $urandom};
      s = {$urandom, $urandom};
      n = $urandom_range(1, 24);
      sig = model_sig(c, s, n);
      if ($urandom_range(0, 1) == 1) sig = sig ^ (64'h1 << $urandom_range(0, 63));
      start_run(c, s, sig, n, 1'b0);
      wait_idle(100);
    end

    // start_i held high: the second run begins one cycle after IDLE is re-entered
    c = {$urandom, $urandom};
    s = {$urandom, $urandom};
    n = 2;
    sig = model_sig(c, s, n);
    coeff_i = c; seed_i = s; golden_i = sig; n_words_i = n; start_i = 1'b1;
    t0 = cyc + 1;
    queue_run(t0, c, s, sig, n, 1'b0);
    queue_run(t0 + longint'(n) + 7, c, s, sig, n, 1'b0);
    while (cyc < t0 + longint'(n) + 7) tick();
    start_i = 1'b0;
    wait_idle(100);

    // Async reset in the middle of a long stream
    start_run({$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 100, 1'b0);
    repeat (20) tick();
    #1 rst_ni = 1'b0;
    bus_q.delete(); word_q.delete(); done_q.delete();
    #1 check_zero("reset_mid_stream");
    tick();
    tick();
    rst_ni = 1'b1;
    repeat (20) tick();
    check_zero("idle_after_mid_reset");

    // Recovery run
    c = {$urandom, $urandom};
    s = {$urandom, $urandom};
    start_run(c, s, model_sig(c, s, 7), 7, 1'b0);
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/misr_bist_sequencer.md
Name: misr_bist_sequencer

Overview:
- Bus initiator that drives the MISR peripheral's register port (re/we/addr/data).
- Runs one self-test per request:
  - clears the MISR and loads its coefficients;
  - enables it and streams N LFSR-generated data words into it;
  - disables it, reads back the signature and compares it to a golden value.
- Sits between the test-control logic and the MISR peripheral. It is the only master on that peripheral's register port during a run.

Parameters:
- NBIT_DATA, 64, width of register data, MISR data, signature and LFSR.
- NBIT_ADDR, 64, width of the register address.
- NBIT_CNT, 32, width of the word-count input.
- START_ADDR, 2**25, MISR peripheral base address. Control = base+0, coefficients = base+8, signature = base+16.
- LFSR_POLY, 64'hD800_0000_0000_0000, Galois LFSR feedback taps for the stimulus generator.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request, sampled in IDLE only.
- coeff_i  in  NBIT_DATA  MISR coefficients, latched on start.
- seed_i  in  NBIT_DATA  LFSR seed, latched on start.
- golden_i  in  NBIT_DATA  expected signature, latched on start.
- n_words_i  in  NBIT_CNT  number of data words N, latched on start.
- re_o  out  1  register read strobe.
- we_o  out  1  register write strobe.
- addr_o  out  NBIT_ADDR  register address.
- wdata_o  out  NBIT_DATA  register write data.
- rdata_i  in  NBIT_DATA  register read data, valid combinationally in the same cycle as re_o.
- data_misr_o  out  NBIT_DATA  stimulus word to the MISR data input.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a run ends.
- pass_o  out  1  comparison result, held until the next start.
- signature_o  out  NBIT_DATA  captured signature, held until the next start.

Behaviour:
- Reset (async):
  - state = IDLE.
  - re_o, we_o, done_o, pass_o, busy_o = 0.
  - addr_o, wdata_o, data_misr_o, signature_o, word counter, LFSR = 0.
  - Reset mid-run abandons the run immediately. No further bus traffic occurs.
- All bus outputs and data_misr_o are decoded from registered state/counter/LFSR only. No combinational path from any input to any output.
- In IDLE, start_i=1 latches coeff_i, seed_i (into LFSR), golden_i and n_words_i, clears pass_o, and moves to CLR. start_i is ignored when not in IDLE.
- FSM sequence, one cycle per state except STREAM:
  - CLR: we_o=1, addr=base+0, wdata=0. Enable=0; reset bit=0 holds the MISR in reset.
  - COEF: we_o=1, addr=base+8, wdata=coeff. Next state is EN if N>0, else STOP.
  - EN: we_o=1, addr=base+0, wdata=2'b11 (enable, out of reset). data_misr_o = word 0.
  - STREAM: N-1 cycles with no bus access. data_misr_o = words 1..N-1. Skipped when N=1.
  - STOP: we_o=1, addr=base+0, wdata=2'b10 (disabled, out of reset). data_misr_o=0.
  - SETTLE: idle cycle so the signature register captures the final MISR state.
  - READ: re_o=1, addr=base+16. rdata_i is latched into signature_o at the end of the cycle.
  - DONE: done_o=1. pass_o = (signature_o == golden latch), registered. Then back to IDLE.
- When no access is in progress, addr_o=0 and wdata_o=0. re_o and we_o are never both 1.
- Stimulus:
  - Word 0 = seed.
  - Each subsequent word is one Galois step: next = (s>>1) ^ (s[0] ? LFSR_POLY : 0).
  - data_misr_o=0 outside the EN/STREAM cycles.
  - A seed of 0 yields all-zero words. This is legal and is not corrected.
- Latency from the start-sample edge:
  - N≥1: CLR in cycle 1, STOP in cycle N+3, READ in cycle N+5, done_o in cycle N+6.
  - N=0: done_o in cycle 6; the signature is the MISR reset value.
- Word counter:
  - NBIT_CNT wide, loaded with N-1 in EN, decrements in STREAM.
  - Leaves STREAM when it reaches 0.
  - N = 2^NBIT_CNT-1 must work with no wrap.
- busy_o=1 from CLR through DONE inclusive.

Test Plan:
- Reset-in-IDLE: hold rst_ni=0, then release -> all outputs 0; no re_o/we_o activity for 20 cycles with start_i=0.
- N=0, coeff=64'h1B, stub responder returns 64'h0 on signature read, golden=0:
  - bus trace is exactly W(base,0), W(base+8,0x1B), W(base,2), R(base+16);
  - done_o in cycle 6; pass_o=1.
- N=3, seed=64'h1, against the MISR reference model:
  - data_misr_o = 0x1, 0xD800_0000_0000_0000, 0x6C00_0000_0000_0000 in cycles 3..5;
  - STOP in cycle 6; done_o in cycle 9; signature_o equals the model value.
- Golden mismatch: same run as the N=3 case, with golden = model signature ^ 1 -> pass_o=0, signature_o unchanged.
- start_i held high throughout a run -> no restart until after DONE; the second run starts exactly one cycle after IDLE is re-entered.
- Async reset asserted during STREAM with N=100 -> all outputs 0 the same cycle; after release, no bus access until a new start_i.
